// File: rtl/panda_pkg.sv
// Shared state encoding and control-word field positions for the PANDA sequencer.
package panda_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    MEM_WAIT = 2'd2,
    DONE     = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    ENTRY_ALU   = 2'd0,
    ENTRY_STORE = 2'd1,
    ENTRY_LOAD  = 2'd2
  } entry_kind_e;

  localparam int         CW_RD_WE_BIT  = 15;
  localparam int         CW_STORE_BIT  = 20;
  localparam int         CW_RD_SEL_LSB = 16;
  localparam logic [1:0] RD_SEL_LOAD   = 2'b01;

  // The store bit wins, so an entry is never treated as both a store and a load.
  function automatic entry_kind_e entry_kind(input logic store_bit, input logic [1:0] rd_sel);
    entry_kind_e kind;
    if (store_bit) begin
      kind = ENTRY_STORE;
    end else if (rd_sel == RD_SEL_LOAD) begin
      kind = ENTRY_LOAD;
    end else begin
      kind = ENTRY_ALU;
    end
    return kind;
  endfunction

endpackage

// File: rtl/panda_cw_store.sv
// Program storage for the control-word sequencer: one write port, one combinational
// read port, every entry cleared by the asynchronous reset.
module panda_cw_store #(
  parameter  int SEQ_DEPTH = 16,
  parameter  int DATA_W    = 60,
  localparam int ADDR_W    = $clog2(SEQ_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] rd_view [SEQ_DEPTH];

  for (genvar gi = 0; gi < SEQ_DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_q;
    logic [DATA_W-1:0] entry_d;

    always_comb begin
      entry_d = entry_q;
      if (we_i && (waddr_i == ADDR_W'(gi))) begin
        entry_d = wdata_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign rd_view[gi] = entry_q;
  end

  assign rdata_o = rd_view[raddr_i];

endmodule

// File: rtl/panda_cw_sequencer.sv
// Steps a stored program of control words into the datapath, handshaking memory entries.
// Optional PANDA_SEQ_PERF_CNT_EN adds saturating busy-cycle and stall-cycle counters.
module panda_cw_sequencer
  import panda_pkg::*;
#(
  parameter  int SEQ_DEPTH = 16,
  parameter  int CW_W      = 28,
  localparam int IDX_W     = $clog2(SEQ_DEPTH),
  localparam int LEN_W     = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             prog_we_i,
  input  logic [IDX_W-1:0] prog_addr_i,
  input  logic [CW_W-1:0]  prog_cw_i,
  input  logic [31:0]      prog_imm_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic [CW_W-1:0]  cw_o,
  output logic [31:0]      imm_o,
  output logic             cw_valid_o,
  output logic             step_o,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  output logic             busy_o,
  output logic             done_o
`ifdef PANDA_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_cnt_o,
  output logic [31:0]      stall_cnt_o
`endif
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [CW_W+31:0] entry_data;
  logic [CW_W-1:0]  entry_cw;
  logic [31:0]      entry_imm;
  entry_kind_e      kind;
  logic             last_entry;
  logic             commit;
  logic             hide_rd_we;
  logic             run_start;

  panda_cw_store #(
    .SEQ_DEPTH (SEQ_DEPTH),
    .DATA_W    (CW_W + 32)
  ) u_store (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (prog_we_i && (state_q == IDLE)),
    .waddr_i (prog_addr_i),
    .wdata_i ({prog_cw_i, prog_imm_i}),
    .raddr_i (idx_q),
    .rdata_o (entry_data)
  );

  assign entry_cw   = entry_data[CW_W+31:32];
  assign entry_imm  = entry_data[31:0];
  assign kind       = entry_kind(entry_cw[CW_STORE_BIT], entry_cw[CW_RD_SEL_LSB +: 2]);
  assign last_entry = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    busy_o     = 1'b0;
    cw_valid_o = 1'b0;
    done_o     = 1'b0;
    data_req_o = 1'b0;
    step_o     = 1'b0;
    commit     = 1'b0;
    hide_rd_we = 1'b0;
    run_start  = 1'b0;
    cw_o       = '0;
    imm_o      = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          run_start = 1'b1;
          idx_d     = '0;
          len_d     = len_i;
          state_d   = (len_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        busy_o = 1'b1;
        unique case (kind)
          ENTRY_STORE: begin
            data_req_o = 1'b1;
            commit     = data_gnt_i;
          end
          ENTRY_LOAD: begin
            data_req_o = 1'b1;
            hide_rd_we = 1'b1;
            if (data_gnt_i) begin
              state_d = MEM_WAIT;
            end
          end
          default: commit = 1'b1;
        endcase
      end
      MEM_WAIT: begin
        busy_o     = 1'b1;
        commit     = data_rvalid_i;
        hide_rd_we = !data_rvalid_i;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cw_valid_o = busy_o;

    // Abort discards the entry in flight: no commit, and a load never exposes rd_we.
    if (busy_o && abort_i) begin
      state_d = IDLE;
      idx_d   = '0;
      if (kind == ENTRY_LOAD) begin
        hide_rd_we = 1'b1;
      end
    end else if (commit) begin
      step_o = 1'b1;
      if (last_entry) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ISSUE;
      end
    end

    if (busy_o) begin
      cw_o  = entry_cw;
      imm_o = entry_imm;
      if (hide_rd_we) begin
        cw_o[CW_RD_WE_BIT] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

`ifdef PANDA_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_event;

  assign stall_event = (data_req_o && !data_gnt_i) ||
                       ((state_q == MEM_WAIT) && !data_rvalid_i);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (run_start) begin
      cycle_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (busy_o && (cycle_cnt_q != '1)) begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
      if (stall_event && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_run_start;
  assign unused_run_start = run_start;
`endif

endmodule

// File: tb/tb_panda_cw_sequencer.sv
// Self-checking bench for panda_cw_sequencer: a per-entry timeline model derived from the
// latency rules drives the memory handshake and predicts every output each cycle.
module tb_panda_cw_sequencer;

  localparam int SEQ_DEPTH = 16;
  localparam int CW_W      = 28;
  localparam int IDX_W     = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             prog_we_i = 1'b0;
  logic [IDX_W-1:0] prog_addr_i = '0;
  logic [CW_W-1:0]  prog_cw_i = '0;
  logic [31:0]      prog_imm_i = '0;
  logic             start_i = 1'b0;
  logic [IDX_W:0]   len_i = '0;
  logic             abort_i = 1'b0;
  logic [CW_W-1:0]  cw_o;
  logic [31:0]      imm_o;
  logic             cw_valid_o;
  logic             step_o;
  logic             data_req_o;
  logic             data_gnt_i = 1'b0;
  logic             data_rvalid_i = 1'b0;
  logic             busy_o;
  logic             done_o;
`ifdef PANDA_SEQ_PERF_CNT_EN
  logic [31:0]      cycle_cnt_o;
  logic [31:0]      stall_cnt_o;
`endif

  panda_cw_sequencer #(.SEQ_DEPTH(SEQ_DEPTH), .CW_W(CW_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .prog_we_i     (prog_we_i),
    .prog_addr_i   (prog_addr_i),
    .prog_cw_i     (prog_cw_i),
    .prog_imm_i    (prog_imm_i),
    .start_i       (start_i),
    .len_i         (len_i),
    .abort_i       (abort_i),
    .cw_o          (cw_o),
    .imm_o         (imm_o),
    .cw_valid_o    (cw_valid_o),
    .step_o        (step_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
`ifdef PANDA_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt_o   (cycle_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model of program contents: kind 0=ALU, 1=store, 2=load; g=grant wait, r=rvalid wait.
  logic [CW_W-1:0] m_cw  [SEQ_DEPTH];
  logic [31:0]     m_imm [SEQ_DEPTH];
  int              m_t   [SEQ_DEPTH];
  int              m_g   [SEQ_DEPTH];
  int              m_r   [SEQ_DEPTH];

  task automatic drive_idle();
    start_i = 1'b0; len_i = '0; abort_i = 1'b0; prog_we_i = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
  endtask

  task automatic set_entry(input int a, input int t, input int g, input int r);
    logic [CW_W-1:0] cw;
    logic [31:0]     imm;
    cw  = CW_W'($urandom);
    imm = $urandom;
    case (t)
      0: begin
        cw[20] = 1'b0;
        if (cw[17:16] == 2'b01) cw[17:16] = 2'b10;
      end
      1: cw[20] = 1'b1;
      default: begin
        cw[20] = 1'b0; cw[17:16] = 2'b01; cw[15] = 1'b1;
      end
    endcase
    @(posedge clk_i); #1;
    prog_we_i = 1'b1; prog_addr_i = IDX_W'(a); prog_cw_i = cw; prog_imm_i = imm;
    @(posedge clk_i); #1;
    prog_we_i = 1'b0;
    m_cw[a] = cw; m_imm[a] = imm; m_t[a] = t; m_g[a] = g; m_r[a] = r;
  endtask

  task automatic run_program(input int len, input string tag);
    int busy_exp = 0, stall_exp = 0, step_obs = 0, dur;
    logic e_req, e_step;
    logic [CW_W-1:0] e_cw;
    @(posedge clk_i); #1;
    drive_idle();
    start_i = 1'b1; len_i = 5'(len);
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || cw_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_cycle: busy=%b cw_valid=%b, required 0/0", tag, busy_o, cw_valid_o);
    end
    for (int k = 0; k < len; k++) begin
      dur = (m_t[k] == 0) ? 1 : (m_t[k] == 1) ? 1 + m_g[k] : 2 + m_g[k] + m_r[k];
      for (int p = 0; p < dur; p++) begin
        @(posedge clk_i); #1;
        drive_idle();
        e_cw = m_cw[k]; e_req = 1'b0; e_step = 1'b0;
        case (m_t[k])
          0: begin
            e_step = 1'b1;
            data_gnt_i = 1'($urandom_range(0, 1)); data_rvalid_i = 1'($urandom_range(0, 1));
          end
          1: begin
            e_req = 1'b1; e_step = (p == m_g[k]); data_gnt_i = (p == m_g[k]);
            data_rvalid_i = 1'($urandom_range(0, 1));
          end
          default: begin
            if (p <= m_g[k]) begin
              e_req = 1'b1; data_gnt_i = (p == m_g[k]);
              data_rvalid_i = 1'($urandom_range(0, 1));
            end else begin
              data_gnt_i = 1'($urandom_range(0, 1));
              data_rvalid_i = (p == dur - 1); e_step = (p == dur - 1);
            end
            if (!e_step) e_cw[15] = 1'b0;
          end
        endcase
        if (e_req && !data_gnt_i) stall_exp++;
        if (m_t[k] == 2 && p > m_g[k] && !data_rvalid_i) stall_exp++;
        busy_exp++;
        @(negedge clk_i);
        checks++;
        if ({busy_o, cw_valid_o, data_req_o, step_o, done_o} !== {1'b1, 1'b1, e_req, e_step, 1'b0}) begin
          errors++;
          $display("FAIL %s_ctrl e%0d c%0d: busy,valid,req,step,done=%b%b%b%b%b, required 11%b%b0",
                   tag, k, p, busy_o, cw_valid_o, data_req_o, step_o, done_o, e_req, e_step);
        end
        checks++;
        if (cw_o !== e_cw || imm_o !== m_imm[k]) begin
          errors++;
          $display("FAIL %s_word e%0d c%0d: cw=%h imm=%h, required cw=%h imm=%h",
                   tag, k, p, cw_o, imm_o, e_cw, m_imm[k]);
        end
        if (step_o === 1'b1) step_obs++;
      end
    end
    @(posedge clk_i); #1;
    drive_idle();
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || cw_valid_o !== 1'b0 || cw_o !== '0 ||
        imm_o !== '0 || step_o !== 1'b0 || data_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_cycle: done=%b busy=%b valid=%b cw=%h imm=%h step=%b req=%b, required done only",
               tag, done_o, busy_o, cw_valid_o, cw_o, imm_o, step_o, data_req_o);
    end
`ifdef PANDA_SEQ_PERF_CNT_EN
    checks++;
    if (cycle_cnt_o !== 32'(busy_exp)) begin
      errors++;
      $display("FAIL %s_cycle_cnt: got %0d, required %0d", tag, cycle_cnt_o, busy_exp);
    end
    checks++;
    if (stall_cnt_o !== 32'(stall_exp)) begin
      errors++;
      $display("FAIL %s_stall_cnt: got %0d, required %0d", tag, stall_cnt_o, stall_exp);
    end
`endif
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b, required 0/0", tag, done_o, busy_o);
    end
    checks++;
    if (step_obs != len) begin
      errors++;
      $display("FAIL %s_step_count: got %0d, required %0d", tag, step_obs, len);
    end
    $display("run %s: len=%0d busy_cycles=%0d stall_cycles=%0d steps=%0d", tag, len, busy_exp, stall_exp, step_obs);
  endtask

  task automatic test_reset();
    drive_idle();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({cw_valid_o, step_o, data_req_o, busy_o, done_o} !== 5'b0 || cw_o !== '0 || imm_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ctrl=%b cw=%h imm=%h, required all 0",
               {cw_valid_o, step_o, data_req_o, busy_o, done_o}, cw_o, imm_o);
    end
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({cw_valid_o, busy_o, done_o} !== 3'b0) begin
      errors++;
      $display("FAIL reset_release: valid,busy,done=%b, required 000", {cw_valid_o, busy_o, done_o});
    end
`ifdef PANDA_SEQ_PERF_CNT_EN
    checks++;
    if (cycle_cnt_o !== '0 || stall_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_counters: cycle=%0d stall=%0d, required 0/0", cycle_cnt_o, stall_cnt_o);
    end
`endif
  endtask

  task automatic test_fixed_program();
    int kinds [8] = '{2, 0, 0, 1, 0, 2, 0, 0};
    for (int i = 0; i < 8; i++) set_entry(i, kinds[i], 0, 0);
    run_program(8, "fixed8");
  endtask

  task automatic test_store_stall();
    set_entry(0, 1, 3, 0);
    run_program(1, "store_stall");
  endtask

  task automatic test_load_rdwe();
    set_entry(0, 2, 0, 2);
    run_program(1, "load_rdwe");
  endtask

  task automatic test_zero_len();
    @(posedge clk_i); #1;
    drive_idle();
    start_i = 1'b1; len_i = '0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1 || cw_valid_o !== 1'b0 || step_o !== 1'b0 || data_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_done: done=%b valid=%b step=%b req=%b busy=%b, required 1/0/0/0/0",
               done_o, cw_valid_o, step_o, data_req_o, busy_o);
    end
`ifdef PANDA_SEQ_PERF_CNT_EN
    checks++;
    if (cycle_cnt_o !== '0 || stall_cnt_o !== '0) begin
      errors++;
      $display("FAIL zero_len_counters: cycle=%0d stall=%0d, required 0/0", cycle_cnt_o, stall_cnt_o);
    end
`endif
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || cw_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: done=%b valid=%b, required 0/0", done_o, cw_valid_o);
    end
  endtask

  task automatic test_abort();
    // Load aborted in MEM_WAIT with rvalid arriving one cycle late.
    set_entry(0, 2, 0, 1);
    @(posedge clk_i); #1;
    drive_idle(); start_i = 1'b1; len_i = 5'd1;
    @(posedge clk_i); #1;
    start_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (data_req_o !== 1'b1 || cw_o[15] !== 1'b0 || step_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_load_issue: req=%b rd_we=%b step=%b, required 1/0/0", data_req_o, cw_o[15], step_o);
    end
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0; abort_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1 || step_o !== 1'b0 || cw_o[15] !== 1'b0 || data_req_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_memwait: busy=%b step=%b rd_we=%b req=%b, required 1/0/0/0",
               busy_o, step_o, cw_o[15], data_req_o);
    end
    @(posedge clk_i); #1;
    abort_i = 1'b0; data_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, cw_valid_o, step_o, done_o} !== 4'b0 || cw_o !== '0) begin
      errors++;
      $display("FAIL abort_late_rvalid: busy,valid,step,done=%b cw=%h, required 0000 and 0",
               {busy_o, cw_valid_o, step_o, done_o}, cw_o);
    end
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b busy=%b, required 0/0", done_o, busy_o);
    end
    // Store aborted in ISSUE: request still up in the abort cycle, gone after.
    set_entry(0, 1, 0, 0);
    @(posedge clk_i); #1;
    start_i = 1'b1; len_i = 5'd1;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (data_req_o !== 1'b1 || step_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_issue_cycle: req=%b step=%b, required 1/0", data_req_o, step_o);
    end
    @(posedge clk_i); #1;
    abort_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({data_req_o, busy_o, step_o, done_o} !== 4'b0) begin
      errors++;
      $display("FAIL abort_req_drop: req,busy,step,done=%b, required 0000", {data_req_o, busy_o, step_o, done_o});
    end
    // Abort and start together in IDLE: abort wins.
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0; start_i = 1'b1; abort_i = 1'b1; len_i = 5'd1;
    @(posedge clk_i); #1;
    drive_idle();
    @(negedge clk_i);
    checks++;
    if ({busy_o, cw_valid_o, done_o} !== 3'b0) begin
      errors++;
      $display("FAIL abort_start_idle: busy,valid,done=%b, required 000", {busy_o, cw_valid_o, done_o});
    end
  endtask

  task automatic test_write_protect_and_reset();
    logic [CW_W-1:0] orig;
    set_entry(0, 1, 0, 0);
    orig = m_cw[0];
    @(posedge clk_i); #1;
    drive_idle(); start_i = 1'b1; len_i = 5'd1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    prog_we_i = 1'b1; prog_addr_i = '0; prog_cw_i = ~orig; prog_imm_i = ~m_imm[0];
    @(posedge clk_i); #1;
    prog_we_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cw_o !== orig || step_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_write_ignored: cw=%h step=%b, required cw=%h step=1", cw_o, step_o, orig);
    end
    @(posedge clk_i); #1;
    drive_idle();
    @(posedge clk_i); #1;
    run_program(1, "rerun_after_busy_write");
    // Reset mid-run clears outputs at once and wipes the program.
    set_entry(0, 0, 0, 0);
    set_entry(1, 0, 0, 0);
    @(posedge clk_i); #1;
    start_i = 1'b1; len_i = 5'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: busy=%b, required 1", busy_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({cw_valid_o, step_o, data_req_o, busy_o, done_o} !== 5'b0 || cw_o !== '0 || imm_o !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: ctrl=%b cw=%h imm=%h, required all 0",
               {cw_valid_o, step_o, data_req_o, busy_o, done_o}, cw_o, imm_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < SEQ_DEPTH; i++) begin
      m_cw[i] = '0; m_imm[i] = '0; m_t[i] = 0; m_g[i] = 0; m_r[i] = 0;
    end
    run_program(2, "rerun_after_reset");
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 20; n++) begin
      len = (n == 0) ? SEQ_DEPTH : $urandom_range(1, SEQ_DEPTH);
      for (int i = 0; i < len; i++)
        set_entry(i, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      run_program(len, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fixed_program();
    test_zero_len();
    test_store_stall();
    test_load_rdwe();
    test_abort();
    test_write_protect_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
